// File: rtl/sa_pkg.sv
// sa_pkg: shared types and constants for the systolic-array load sequencer.
//   seq_state_t  - sequencer FSM states
//   compute_len  - number of streaming cycles the array needs for a DIM x DIM job
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_A  = 3'd2,
    COMPUTE = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  function automatic int compute_len(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/sa_load_sequencer_if.sv
// sa_load_sequencer_if: row stream from the host loader plus the memA/memB
// drive bundle.
//   row_valid/row_ready/row_data : upstream valid/ready row stream
//   Ain, Arow, WrEn              : memA write port
//   Bin                          : memB shift-in data
//   en                           : shared memA/memB shift/stream enable
// Modports: master = sequencer side, slave = loader/datapath side.
interface sa_load_sequencer_if #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
);
  localparam int ROWBITS = $clog2(DIM);

  logic                   row_valid;
  logic                   row_ready;
  logic [DIM*BITS_AB-1:0] row_data;
  logic [DIM*BITS_AB-1:0] Ain;
  logic [DIM*BITS_AB-1:0] Bin;
  logic [ROWBITS-1:0]     Arow;
  logic                   WrEn;
  logic                   en;

  modport master (
    input  row_valid, row_data,
    output row_ready, Ain, Bin, Arow, WrEn, en
  );

  modport slave (
    output row_valid, row_data,
    input  row_ready, Ain, Bin, Arow, WrEn, en
  );
endinterface

// File: rtl/sa_seq_counter.sv
// sa_seq_counter: up-counter with synchronous clear and increment enable.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count enable
//   cnt        : current count (W bits)
//   tc         : high while cnt equals TC
module sa_seq_counter #(
  parameter int          W  = 4,
  parameter int unsigned TC = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);
  localparam logic [W-1:0] TC_V = W'(TC);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == TC_V);
endmodule

// File: rtl/sa_load_sequencer.sv
// sa_load_sequencer: sequences one matrix-multiply job. Loads DIM B rows
// (shifted into memB via en), then DIM A rows (written into memA via
// WrEn/Arow), then holds en for 3*DIM-2 streaming cycles and pulses done.
//   clk, rst_n    : clock, synchronous active-low reset
//   start, keep_b : job command (sampled in IDLE); keep_b skips the B load
//   bus (master)  : row stream in, memA/memB drive out
//   busy, done    : job status; done is a one-cycle pulse
// Optional build macro SA_SEQ_PERF_EN adds stall_cycles / job_cycles
// (saturating, cleared on accepted start and reset).
module sa_load_sequencer
  import sa_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       keep_b,
  sa_load_sequencer_if.master        bus,
  output logic                       busy,
  output logic                       done
`ifdef SA_SEQ_PERF_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                job_cycles
`endif
);
  localparam int          ROWBITS = $clog2(DIM);
  localparam int          CYCW    = $clog2(3 * DIM);
  localparam int unsigned CLEN    = compute_len(DIM);
  localparam int          RW      = DIM * BITS_AB;

  seq_state_t state, state_n;

  logic               hs;
  logic               row_clr, cyc_clr, cyc_inc;
  logic [ROWBITS:0]   row_cnt;
  logic               row_tc;
  logic [CYCW-1:0]    cyc_cnt;
  logic               cyc_tc;
  logic               unused_cyc;

  logic               en_b_p1;
  logic               wr_p1;
  logic [RW-1:0]      ain_p1;
  logic [RW-1:0]      bin_p1;
  logic [ROWBITS-1:0] arow_p1;

  assign bus.row_ready = (state == LOAD_B) || (state == LOAD_A);
  assign hs            = bus.row_valid && bus.row_ready;

  // The first COMPUTE cycle is always the final A write; streaming waits one
  // cycle so memA is never written and streamed together.
  assign cyc_inc = (state == COMPUTE) && !wr_p1;

  sa_seq_counter #(.W(ROWBITS + 1), .TC(DIM - 1)) u_row_cnt (
    .clk(clk), .rst_n(rst_n), .clr(row_clr), .inc(hs), .cnt(row_cnt), .tc(row_tc)
  );

  sa_seq_counter #(.W(CYCW), .TC(CLEN - 1)) u_cyc_cnt (
    .clk(clk), .rst_n(rst_n), .clr(cyc_clr), .inc(cyc_inc), .cnt(cyc_cnt), .tc(cyc_tc)
  );

  // Only the terminal flag of the cycle counter is consumed.
  assign unused_cyc = ^cyc_cnt;

  always_comb begin
    state_n = state;
    row_clr = 1'b0;
    cyc_clr = 1'b0;
    unique case (state)
      IDLE: begin
        row_clr = 1'b1;
        cyc_clr = 1'b1;
        if (start) state_n = keep_b ? LOAD_A : LOAD_B;
      end
      LOAD_B: begin
        if (hs && row_tc) begin
          state_n = LOAD_A;
          row_clr = 1'b1;
        end
      end
      LOAD_A: begin
        if (hs && row_tc) state_n = COMPUTE;
      end
      COMPUTE: begin
        if (cyc_inc && cyc_tc) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stage p1: registered memA/memB write, one cycle after the handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      en_b_p1 <= 1'b0;
      wr_p1   <= 1'b0;
      ain_p1  <= '0;
      bin_p1  <= '0;
      arow_p1 <= '0;
    end else begin
      state   <= state_n;
      en_b_p1 <= (state == LOAD_B) && hs;
      wr_p1   <= (state == LOAD_A) && hs;
      if ((state == LOAD_B) && hs) bin_p1 <= bus.row_data;
      if ((state == LOAD_A) && hs) begin
        ain_p1  <= bus.row_data;
        arow_p1 <= ROWBITS'(row_cnt);
      end
    end
  end

  assign bus.Ain  = ain_p1;
  assign bus.Bin  = bin_p1;
  assign bus.Arow = arow_p1;
  assign bus.WrEn = wr_p1;
  assign bus.en   = en_b_p1 || cyc_inc;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

`ifdef SA_SEQ_PERF_EN
  logic load_st;
  assign load_st = (state == LOAD_B) || (state == LOAD_A);

  always_ff @(posedge clk) begin
    if (!rst_n || ((state == IDLE) && start)) begin
      stall_cycles <= '0;
      job_cycles   <= '0;
    end else begin
      if (load_st && !bus.row_valid && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (busy && (job_cycles != '1))
        job_cycles <= job_cycles + 32'd1;
    end
  end
`endif

endmodule
